// File: rtl/idx_dispatch.sv
// idx_dispatch: 2-entry FIFO that routes each payload to one of M consumers by binary index
// Out-of-range indices are accepted, dropped, and counted in a saturating err_cnt.
module idx_dispatch #(
  parameter int N = 2,
  parameter int M = 4,
  parameter int K = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_idx,
  input  logic [K-1:0] in_data,
  output logic [M-1:0] out_valid,
  input  logic [M-1:0] out_ready,
  output logic [K-1:0] out_data,
  output logic         err,
  output logic [7:0]   err_cnt
);
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] FULL = 2'd2;
  localparam logic [N:0] MLIM = M[N:0];
  logic [1:0] count;
  logic wptr, rptr;
  logic [N-1:0] idx_q [2];
  logic [K-1:0] data_q [2];
  logic acc, bad, push, pop;
  assign in_ready = rst_n & (count != FULL);
  assign acc = in_valid & in_ready;
  // bad is constant 0 when M == 2^N, so the drop path vanishes
  assign bad = {1'b0, in_idx} >= MLIM;
  assign push = acc & ~bad;
  assign pop = |(out_valid & out_ready);
  assign out_data = data_q[rptr];
  always_comb begin
    out_valid = '0;
    for (int i = 0; i < M; i++)
      out_valid[i] = (count != EMPTY) && (idx_q[rptr] == i[N-1:0]);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= EMPTY;
      wptr <= 1'b0;
      rptr <= 1'b0;
      err <= 1'b0;
      err_cnt <= 8'd0;
      idx_q <= '{default: '0};
      data_q <= '{default: '0};
    end else begin
      if (push) begin
        idx_q[wptr] <= in_idx;
        data_q[wptr] <= in_data;
        wptr <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      count <= count + {1'b0, push} - {1'b0, pop};
      err <= acc & bad;
      if (acc & bad & (err_cnt != 8'hff)) err_cnt <= err_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_idx_dispatch.sv
// tb_idx_dispatch: drives an M=4 and an M=3 instance with shared stimulus and checks both
// against a queue-based reference model, plus directed vector tables and corner sequences.
module tb_idx_dispatch;
  typedef struct { logic [1:0] idx; logic [7:0] data; } ent_t;
  typedef struct packed {
    logic v; logic [1:0] idx; logic [7:0] d; logic [3:0] rdy;
    logic [3:0] ov; logic [7:0] od; logic ir;
  } vec_t;
  logic clk = 0, rst_n = 0, in_valid = 0;
  logic [1:0] in_idx = 0;
  logic [7:0] in_data = 0;
  logic [3:0] out_ready = 0;
  logic ir_a, ir_b, err_a, err_b;
  logic [3:0] ov_a;
  logic [2:0] ov_b;
  logic [7:0] od_a, od_b, ec_a, ec_b;
  int checks = 0, errors = 0;
  ent_t q[2][$];
  int ecnt[2];
  logic erre[2];
  int mlim[2] = '{4, 3};
  vec_t tv[$];

  always #5 clk = ~clk;

  idx_dispatch #(.N(2), .M(4), .K(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_a),
    .in_idx(in_idx), .in_data(in_data), .out_valid(ov_a), .out_ready(out_ready),
    .out_data(od_a), .err(err_a), .err_cnt(ec_a)
  );
  idx_dispatch #(.N(2), .M(3), .K(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_b),
    .in_idx(in_idx), .in_data(in_data), .out_valid(ov_b), .out_ready(out_ready[2:0]),
    .out_data(od_b), .err(err_b), .err_cnt(ec_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_check();
    for (int j = 0; j < 2; j++) begin
      logic [31:0] ov, eov;
      ov = (j != 0) ? 32'(ov_b) : 32'(ov_a);
      eov = (q[j].size() != 0) ? (32'd1 << q[j][0].idx) : 32'd0;
      chk($sformatf("m%0d in_ready", j), 32'((j != 0) ? ir_b : ir_a), 32'(rst_n && q[j].size() < 2));
      chk($sformatf("m%0d out_valid", j), ov, eov);
      if (q[j].size() != 0)
        chk($sformatf("m%0d out_data", j), 32'((j != 0) ? od_b : od_a), 32'(q[j][0].data));
      chk($sformatf("m%0d err", j), 32'((j != 0) ? err_b : err_a), 32'(erre[j]));
      chk($sformatf("m%0d err_cnt", j), 32'((j != 0) ? ec_b : ec_a), 32'(ecnt[j]));
    end
  endtask

  task automatic model_update();
    for (int j = 0; j < 2; j++) begin
      logic acc, bad;
      ent_t e;
      if (!rst_n) begin
        q[j].delete();
        ecnt[j] = 0;
        erre[j] = 0;
      end else begin
        acc = in_valid && q[j].size() < 2;
        bad = int'(in_idx) >= mlim[j];
        if (q[j].size() != 0 && out_ready[q[j][0].idx]) void'(q[j].pop_front());
        if (acc && !bad) begin
          e.idx = in_idx;
          e.data = in_data;
          q[j].push_back(e);
        end
        erre[j] = acc && bad;
        if (erre[j] && ecnt[j] < 255) ecnt[j]++;
      end
    end
  endtask

  task automatic step();
    #1;
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic add(input logic v, input logic [1:0] idx, input logic [7:0] d,
                     input logic [3:0] rdy, input logic [3:0] ov, input logic [7:0] od,
                     input logic ir);
    vec_t t;
    t = '{v: v, idx: idx, d: d, rdy: rdy, ov: ov, od: od, ir: ir};
    tv.push_back(t);
  endtask

  task automatic drive(input logic v, input logic [1:0] idx, input logic [7:0] d,
                       input logic [3:0] rdy);
    in_valid = v;
    in_idx = idx;
    in_data = d;
    out_ready = rdy;
  endtask

  initial begin
    // single push, hold, wrong-channel ready, pop; then backpressure and full
    add(1, 2, 8'hA5, 4'b0000, 4'b0000, 8'h00, 1);
    add(0, 0, 8'h00, 4'b0000, 4'b0100, 8'hA5, 1);
    add(0, 0, 8'h00, 4'b1011, 4'b0100, 8'hA5, 1);
    add(0, 0, 8'h00, 4'b0100, 4'b0100, 8'hA5, 1);
    add(1, 1, 8'h11, 4'b0000, 4'b0000, 8'h00, 1);
    add(1, 3, 8'h33, 4'b0000, 4'b0010, 8'h11, 1);
    add(1, 0, 8'h44, 4'b0000, 4'b0010, 8'h11, 0);
    add(1, 0, 8'h44, 4'b1111, 4'b0010, 8'h11, 0);
    add(1, 0, 8'h44, 4'b1111, 4'b1000, 8'h33, 1);
    add(0, 0, 8'h00, 4'b1111, 4'b0001, 8'h44, 1);
    add(1, 0, 8'h55, 4'b0000, 4'b0000, 8'h00, 1);
    add(0, 0, 8'h00, 4'b1110, 4'b0001, 8'h55, 1);
    add(0, 0, 8'h00, 4'b1110, 4'b0001, 8'h55, 1);
    add(0, 0, 8'h00, 4'b1110, 4'b0001, 8'h55, 1);
    add(0, 0, 8'h00, 4'b0001, 4'b0001, 8'h55, 1);
    add(0, 0, 8'h00, 4'b0000, 4'b0000, 8'h00, 1);

    rst_n = 0;
    @(posedge clk);
    model_update();
    #1;
    step();
    chk("reset in_ready", 32'(ir_a), 0);
    rst_n = 1;

    foreach (tv[i]) begin
      drive(tv[i].v, tv[i].idx, tv[i].d, tv[i].rdy);
      #1;
      chk($sformatf("tv%0d out_valid", i), 32'(ov_a), 32'(tv[i].ov));
      if (tv[i].ov != 0) chk($sformatf("tv%0d out_data", i), 32'(od_a), 32'(tv[i].od));
      chk($sformatf("tv%0d in_ready", i), 32'(ir_a), 32'(tv[i].ir));
      step();
    end

    // streaming: one entry per cycle, in order
    for (int i = 0; i < 8; i++) begin
      drive(1, 2'(i % 4), 8'(i), 4'b1111);
      #1;
      chk("stream in_ready", 32'(ir_a), 1);
      if (i > 0) begin
        chk("stream out_valid", 32'(ov_a), 32'd1 << ((i - 1) % 4));
        chk("stream out_data", 32'(od_a), 32'(i - 1));
      end
      step();
    end
    drive(0, 0, 0, 4'b1111);
    step();

    // out-of-range on the M=3 instance
    rst_n = 0;
    step();
    rst_n = 1;
    drive(1, 3, 8'h77, 4'b0000);
    step();
    chk("oor err", 32'(err_b), 1);
    chk("oor err_cnt", 32'(ec_b), 1);
    drive(1, 1, 8'h22, 4'b0000);
    step();
    chk("oor err once", 32'(err_b), 0);
    chk("oor out_valid", 32'(ov_b), 32'b010);
    chk("oor out_data", 32'(od_b), 32'h22);
    drive(0, 0, 0, 4'b1111);
    step();
    step();
    drive(1, 3, 8'h99, 4'b1111);
    repeat (300) step();
    drive(0, 0, 0, 4'b1111);
    step();
    chk("sat err_cnt", 32'(ec_b), 255);
    chk("full-range err_cnt", 32'(ec_a), 0);
    chk("full-range err", 32'(err_a), 0);

    // reset while full
    drive(1, 1, 8'h11, 4'b0000);
    step();
    drive(1, 2, 8'h22, 4'b0000);
    step();
    drive(0, 0, 0, 4'b0000);
    step();
    chk("full in_ready", 32'(ir_a), 0);
    rst_n = 0;
    step();
    rst_n = 1;
    chk("rst out_valid", 32'(ov_a), 0);
    chk("rst err_cnt b", 32'(ec_b), 0);
    chk("rst err b", 32'(err_b), 0);
    drive(0, 0, 0, 4'b1111);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stale out_valid", 32'(ov_a), 0);
      step();
    end

    // randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom), 4'($urandom));
      step();
    end
    rst_n = 1;
    drive(0, 0, 0, 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/idx_dispatch.md
Name: idx_dispatch

Overview:
- Sequential counterpart to the arbiter/encoder path.
- Accepts a binary-encoded destination index plus payload over a valid/ready handshake and buffers it in a 2-entry FIFO.
- Decodes the head index to a one-hot valid and presents it to M consumers that share one data bus.
- Out-of-range indices are consumed, dropped and counted.

Parameters:
- N, 2, width of destination index.
- M, 4, number of consumer channels, 1 <= M <= 2^N.
- K, 8, payload width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  producer has an entry.
- in_ready  out  1  block can accept.
- in_idx  in  N  binary destination index.
- in_data  in  K  payload.
- out_valid  out  M  one-hot valid, at most one bit set.
- out_ready  in  M  per-consumer ready.
- out_data  out  K  head payload, shared by all consumers.
- err  out  1  one-cycle pulse: an out-of-range entry was dropped.
- err_cnt  out  8  saturating count of dropped entries.

Behaviour:
- One clock; reset is synchronous and active-low. All state is sampled on the rising edge of clk while rst_n is low.
- Reset values:
  - FIFO count = 0, read/write pointers = 0.
  - out_valid = 0, out_data = 0, err = 0, err_cnt = 0.
  - in_ready = 0 while rst_n is low.
- State is the FIFO occupancy: EMPTY (0), ONE (1), FULL (2).
- in_ready = rst_n & (count != 2). It depends on state only, never on in_valid or out_ready.
- Push: in_valid & in_ready at an edge writes {in_idx, in_data} at wptr; wptr toggles.
- Range check happens on the write side:
  - An entry with in_idx >= M is never stored and does not change count or wptr.
  - err = 1 in the following cycle only.
  - err_cnt increments and saturates at 255.
- Output decode from the head entry:
  - out_valid = (count != 0) ? (1 << head_idx) : 0.
  - out_data = head payload, or the last value when empty; don't-care when out_valid = 0.
- Pop: an edge where the bit of out_valid that is set also has its out_ready bit set. rptr toggles.
  - out_ready bits of other channels are ignored.
- Latency: an entry pushed at edge t is visible on out_valid at t+1 if the FIFO was empty. Minimum latency is 1 cycle, with no combinational path from input to output.
- Throughput: one entry per cycle sustained while the addressed consumer holds ready high.
- Simultaneous push and pop:
  - EMPTY: push only; pop is impossible.
  - ONE: count stays 1; head advances.
  - FULL: in_ready = 0, so pop only, count -> 1.
- Dropped entry with a simultaneous pop: count decrements normally.
- Head is stable: out_valid and out_data hold unchanged until popped, regardless of later pushes.
- Reset mid-operation: both FIFO entries are discarded, out_valid goes to 0 at the next edge, err_cnt clears, no err pulse.
- Pointer wrap: 1-bit pointers wrap naturally; ordering is strict FIFO across wrap.
- M < 2^N: indices in M..2^N-1 follow the drop rule.
- M = 2^N: the drop path is unreachable and err stays 0.

Test Plan:
1. Reset then single push: hold rst_n = 0 for 2 cycles, confirm in_ready = 0. Release, push idx = 2, data = 0xA5 with out_ready = 4'b0000.
   -> out_valid = 4'b0100 and out_data = 0xA5 from the next cycle, held stable until out_ready[2] = 1; popped on that edge, then out_valid = 0.
2. Backpressure/full: out_ready = 0; push idx 1 data 0x11, then idx 3 data 0x33.
   -> in_ready = 0 after the second push; third offer (idx 0, 0x44) is not accepted.
   -> raise out_ready = 4'b1111: outputs 0x11 on out_valid = 0010, then 0x33 on out_valid = 1000, one per cycle.
   -> 0x44 is accepted when in_ready returns.
3. Streaming: in_valid = 1 for 8 cycles, idx = i mod 4, data = i, all out_ready = 1.
   -> 8 pops on consecutive cycles in order, out_valid cycling 0001, 0010, 0100, 1000.
   -> count never exceeds 1; in_ready stays 1.
4. Wrong-channel ready: head idx = 0, out_ready = 4'b1110 for 3 cycles.
   -> no pop, out_valid = 0001 held; pop occurs on the cycle out_ready[0] = 1.
5. Out-of-range with M = 3, N = 2: push idx = 3 data 0x77, then idx 1 data 0x22.
   -> err = 1 for exactly one cycle, err_cnt = 1, only 0x22 delivered on out_valid = 010.
   -> 300 bad pushes -> err_cnt = 255, no wrap.
6. Reset mid-operation: FIFO FULL, assert rst_n = 0 for 1 cycle.
   -> out_valid = 0, err_cnt = 0 next cycle, stale entries never appear after release.
